router_sync_ctrl: RTL and testbench

- Synchronizer/controller between the router's header FSM and the three output FIFOs of the 1x3 router.
- Latches the destination address from the header byte and steers the single write enable to one FIFO.
- Muxes that FIFO's full flag back to the FSM and generates a valid_out per port.
- Issues a one-cycle soft_reset to any port whose reader leaves valid data untouched for TIMEOUT consecutive cycles.

---
 rtl/router_sync_ctrl.sv | 132 +++++++++++++
 tb/tb_router_sync_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/router_sync_ctrl.sv
`default_nettype none
// router_sync_ctrl: header address latch, FIFO write steering, full/valid muxing and per-port stall timeout.
// Optional macro ROUTER_TIMEOUT_STAT_EN adds stat_clr / to_events (saturating soft_reset event count).
module router_sync_ctrl #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
`ifdef ROUTER_TIMEOUT_STAT_EN
  input  logic       stat_clr,
  output logic [7:0] to_events,
`endif
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2,
  output logic       addr_err
);

  logic [1:0] r_addr;
  logic       r_addr_vld;
  logic       r_addr_err;
  logic [2:0] w_vld;
  logic [2:0] w_rd;
  logic [2:0] w_sr;

  assign w_vld = ~{empty_2, empty_1, empty_0};
  assign w_rd  = {read_enb_2, read_enb_1, read_enb_0};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr     <= 2'b00;
      r_addr_vld <= 1'b0;
      r_addr_err <= 1'b0;
    end else if (detect_add) begin
      r_addr     <= data_in;
      r_addr_vld <= (data_in != 2'b11);
      r_addr_err <= (data_in == 2'b11);
    end
  end

  // Address 2'b11 never reaches here with r_addr_vld set, so default covers it.
  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    if (r_addr_vld) begin
      case (r_addr)
        2'b00:   begin write_enb = {2'b00, write_enb_reg}; fifo_full = full_0; end
        2'b01:   begin write_enb = {1'b0, write_enb_reg, 1'b0}; fifo_full = full_1; end
        2'b10:   begin write_enb = {write_enb_reg, 2'b00}; fifo_full = full_2; end
        default: begin write_enb = 3'b000; fifo_full = 1'b0; end
      endcase
    end
  end

  generate
    for (genvar i = 0; i < 3; i++) begin : g_port
      logic [CNT_W-1:0] r_cnt;
      logic             r_sr;
      logic             w_stall;

      assign w_stall = w_vld[i] & ~w_rd[i];

      // The clear at TIMEOUT-1 keeps the counter from ever wrapping.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_cnt <= '0;
          r_sr  <= 1'b0;
        end else if (!w_stall) begin
          r_cnt <= '0;
          r_sr  <= 1'b0;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          r_cnt <= '0;
          r_sr  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          r_sr  <= 1'b0;
        end
      end

      assign w_sr[i] = r_sr;
    end
  endgenerate

`ifdef ROUTER_TIMEOUT_STAT_EN
  logic [7:0] r_events;
  logic [9:0] w_ev_sum;

  assign w_ev_sum = {2'b00, r_events} + {9'b0, w_sr[0]} + {9'b0, w_sr[1]} + {9'b0, w_sr[2]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_events <= 8'h00;
    end else if (stat_clr) begin
      r_events <= 8'h00;
    end else if (w_ev_sum > 10'd255) begin
      r_events <= 8'hFF;
    end else begin
      r_events <= w_ev_sum[7:0];
    end
  end

  assign to_events = r_events;
`endif

  assign vld_out_0    = w_vld[0];
  assign vld_out_1    = w_vld[1];
  assign vld_out_2    = w_vld[2];
  assign soft_reset_0 = w_sr[0];
  assign soft_reset_1 = w_sr[1];
  assign soft_reset_2 = w_sr[2];
  assign addr_err     = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_router_sync_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// tb_router_sync_ctrl: table vectors, hand-written timeout sequences and random stimulus
// checked against a behavioural model of the router sync controller.
module tb_router_sync_ctrl;
  localparam int TIMEOUT = 30;
  localparam int CNT_W   = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic [2:0] empty, full, rd;
  logic       stat_clr;
  logic [2:0] write_enb;
  logic       fifo_full, addr_err;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic [7:0] to_events_w;

  always #5 clock = ~clock;

  router_sync_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg),
    .empty_0(empty[0]), .empty_1(empty[1]), .empty_2(empty[2]),
    .full_0(full[0]), .full_1(full[1]), .full_2(full[2]),
    .read_enb_0(rd[0]), .read_enb_1(rd[1]), .read_enb_2(rd[2]),
`ifdef ROUTER_TIMEOUT_STAT_EN
    .stat_clr(stat_clr), .to_events(to_events_w),
`endif
    .write_enb(write_enb), .fifo_full(fifo_full),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .addr_err(addr_err)
  );
`ifndef ROUTER_TIMEOUT_STAT_EN
  assign to_events_w = 8'h00;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model: latched header state plus run length of consecutive stalled cycles.
  logic [1:0] m_addr;
  logic       m_vld, m_err;
  int         m_run [3];
  logic [2:0] m_sr;
  int         m_ev;

  task automatic model_reset();
    m_addr = 2'b00; m_vld = 1'b0; m_err = 1'b0; m_sr = 3'b000; m_ev = 0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    int pulses;
    pulses = $countones(m_sr);
    if (stat_clr) m_ev = 0;
    else m_ev = (m_ev + pulses > 255) ? 255 : m_ev + pulses;
    if (detect_add) begin
      m_addr = data_in;
      m_vld  = (data_in != 2'd3);
      m_err  = (data_in == 2'd3);
    end
    for (int i = 0; i < 3; i++) begin
      m_sr[i] = 1'b0;
      if (!empty[i] && !rd[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == TIMEOUT) begin
          m_sr[i]  = 1'b1;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [18:0] act, exp;
    logic [2:0]  ewe;
    logic        eff;
    ewe = (write_enb_reg && m_vld) ? (3'b001 << m_addr) : 3'b000;
    eff = m_vld ? full[m_addr] : 1'b0;
    act = {write_enb, fifo_full, vld_out_2, vld_out_1, vld_out_0,
           soft_reset_2, soft_reset_1, soft_reset_0, addr_err, to_events_w};
    exp = {ewe, eff, ~empty, m_sr, m_err, 8'h00};
`ifdef ROUTER_TIMEOUT_STAT_EN
    exp[7:0] = m_ev[7:0];
`endif
    chk(tag, {13'b0, act}, {13'b0, exp});
  endtask

  task automatic cycle(input string tag);
    @(posedge clock);
    if (!reset) model_edge();
    @(negedge clock);
    check_all(tag);
  endtask

  task automatic set_idle();
    detect_add = 1'b0; data_in = 2'b00; write_enb_reg = 1'b0;
    full = 3'b000; empty = 3'b111; rd = 3'b000; stat_clr = 1'b0;
  endtask

  task automatic async_reset();
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_sr", {29'b0, soft_reset_2, soft_reset_1, soft_reset_0}, 32'd0);
    check_all("rst_all");
    cycle("rst_hold");
    reset = 1'b0;
  endtask

  typedef struct {
    logic       det;
    logic [1:0] din;
    logic       wr;
    logic [2:0] full;
    logic [2:0] exp_we;
    logic       exp_ff;
    logic       exp_err;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{1'b1, 2'b01, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 2'b00, 1'b1, 3'b000, 3'b010, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 2'b00, 1'b1, 3'b010, 3'b010, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 2'b00, 1'b1, 3'b101, 3'b010, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 2'b11, 1'b1, 3'b111, 3'b000, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 2'b00, 1'b1, 3'b111, 3'b000, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 2'b10, 1'b1, 3'b100, 3'b100, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 2'b00, 1'b1, 3'b000, 3'b100, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 2'b00, 1'b1, 3'b001, 3'b001, 1'b1, 1'b0};

    set_idle();
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    chk("reset_we", {29'b0, write_enb}, 32'd0);
    chk("reset_ff_err", {30'b0, fifo_full, addr_err}, 32'd0);
    chk("reset_sr", {29'b0, soft_reset_2, soft_reset_1, soft_reset_0}, 32'd0);
    chk("reset_vld_idle", {29'b0, vld_out_2, vld_out_1, vld_out_0}, 32'd0);
    empty = 3'b010;
    #1;
    chk("reset_vld_follow", {29'b0, vld_out_2, vld_out_1, vld_out_0}, 32'b101);
    chk("reset_sr_stalled", {29'b0, soft_reset_2, soft_reset_1, soft_reset_0}, 32'd0);
    @(negedge clock);
    set_idle();
    reset = 1'b0;

    // Address latch / steering vectors
    foreach (vecs[k]) begin
      detect_add = vecs[k].det; data_in = vecs[k].din;
      write_enb_reg = vecs[k].wr; full = vecs[k].full;
      cycle("vec_model");
      chk("vec_we", {29'b0, write_enb}, {29'b0, vecs[k].exp_we});
      chk("vec_ff", {31'b0, fifo_full}, {31'b0, vecs[k].exp_ff});
      chk("vec_err", {31'b0, addr_err}, {31'b0, vecs[k].exp_err});
    end

    // Header latch on port 1 followed by a 12-byte write burst
    set_idle();
    detect_add = 1'b1; data_in = 2'b01;
    cycle("burst_hdr");
    detect_add = 1'b0;
    for (int n = 0; n < 12; n++) begin
      write_enb_reg = 1'b1;
      full = 3'($urandom_range(0, 7));
      if (n == 11) full[1] = 1'b1;
      cycle("burst");
      chk("burst_we", {29'b0, write_enb}, 32'b010);
      chk("burst_ff", {31'b0, fifo_full}, {31'b0, full[1]});
    end

    // Port 0 stalls for two full timeouts
    set_idle();
    cycle("idle");
    empty = 3'b110;
    for (int n = 1; n <= 2 * TIMEOUT; n++) begin
      cycle("p0_stall");
      chk("p0_pulse", {31'b0, soft_reset_0}, {31'b0, (n == TIMEOUT || n == 2 * TIMEOUT)});
    end

    // Port 2 read on the last stalled cycle before timeout
    set_idle();
    cycle("idle");
    empty = 3'b011;
    for (int n = 1; n <= 2 * TIMEOUT + 2; n++) begin
      rd[2] = (n == TIMEOUT);
      cycle("p2_stall");
      chk("p2_pulse", {31'b0, soft_reset_2}, {31'b0, (n == 2 * TIMEOUT)});
    end

    // Ports 0 and 1 together, reset during a pulse and mid-count
    set_idle();
    cycle("idle");
    empty = 3'b100;
    for (int n = 1; n <= TIMEOUT; n++) begin
      cycle("p01_stall");
      chk("p01_pulse", {30'b0, soft_reset_1, soft_reset_0}, (n == TIMEOUT) ? 32'b11 : 32'b00);
    end
    async_reset();
    for (int n = 1; n <= 15; n++) cycle("p01_pre");
    async_reset();
    for (int n = 1; n <= TIMEOUT; n++) begin
      cycle("p01_restart");
      chk("p01_restart_pulse", {30'b0, soft_reset_1, soft_reset_0}, (n == TIMEOUT) ? 32'b11 : 32'b00);
    end

`ifdef ROUTER_TIMEOUT_STAT_EN
    set_idle();
    async_reset();
    empty = 3'b000;
    for (int n = 1; n <= 2 * TIMEOUT + 1; n++) cycle("stat_stall");
    chk("stat_six", {24'b0, to_events_w}, 32'd6);
    stat_clr = 1'b1;
    cycle("stat_clr");
    stat_clr = 1'b0;
    chk("stat_clr", {24'b0, to_events_w}, 32'd0);
    for (int n = 1; n <= 100 * TIMEOUT + 1; n++) cycle("stat_sat");
    chk("stat_sat", {24'b0, to_events_w}, 32'd255);
`endif

    // Random traffic against the model
    set_idle();
    for (int n = 0; n < 800; n++) begin
      detect_add    = ($urandom_range(0, 7) == 0);
      data_in       = 2'($urandom_range(0, 3));
      write_enb_reg = 1'($urandom_range(0, 1));
      full          = 3'($urandom_range(0, 7));
      stat_clr      = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 3; i++) begin
        empty[i] = ($urandom_range(0, 19) == 0);
        rd[i]    = ($urandom_range(0, 39) == 0);
      end
      cycle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
